ifu_prefetch: RTL and testbench
===============================

# ifu_prefetch

Parametrised instruction fetch unit for the multi-cycle and pipelined cores; the successor to the single-cycle fetch stage. It issues in-order instruction memory reads over a valid/ready request channel and keeps several requests in flight. Responses are buffered in a FIFO_DEPTH-entry prefetch queue that presents {pc, instruction} to decode with a valid/ready handshake. Redirects (branch/jump/trap) flush the queue, drop stale in-flight responses and restart fetch at the target.

## Interface
- XLEN, 32, address/PC width.
- PC_RST_VEC, 32'h00000000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch queue entries and maximum in-flight plus buffered fetches; power of 2, ≥2.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (= fetch_pc).
- imem_rsp_valid  in  1  read data returned; in order, one per accepted request, never earlier than the cycle after acceptance; always accepted.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  single-cycle redirect strobe.
- redirect_pc  in  XLEN  redirect target.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head.
- inst_data  out  32  head instruction.
- inst_pc  out  XLEN  head PC.
- fetch_pc  out  XLEN  next address to request.
- fault  out  1  misaligned redirect fault (see Configuration).
- fault_pc  out  XLEN  offending target.

## Operation
- Counters: inflight (requests accepted, response not yet returned), occ (queue occupancy), discard (in-flight responses to drop); each is clog2(FIFO_DEPTH)+1 bits.
- Credit: credit_ok = inflight + occ < FIFO_DEPTH, evaluated from registered values. imem_req_valid = credit_ok && !fault && !rst. The value is combinational from registers and does not depend on redirect_valid.
- Request handshake (valid && ready): fetch_pc += 4 (wraps modulo 2^XLEN), inflight += 1.
- Response: inflight -= 1.
  - If discard > 0: data dropped, discard -= 1.
  - Else: {rsp_pc, data} pushed to queue, rsp_pc += 4.
  - The queue never overflows; this is guaranteed by credit.
- Decode handshake (inst_valid && inst_ready): pop head, occ -= 1.
- Redirect (redirect_valid = 1):
  - fetch_pc and rsp_pc load redirect_pc.
  - Queue is flushed (occ = 0); any same-cycle pop or push is ignored.
  - discard = inflight + (request accepted this cycle ? 1 : 0) − (response this cycle ? 1 : 0).
  - A request accepted in the redirect cycle used the old address and is discarded.
- Simultaneous request, response and pop in one cycle: all counters update by their net change.
- Reset values: fetch_pc = rsp_pc = PC_RST_VEC; inflight = occ = discard = 0; inst_valid = 0; imem_req_valid = 0 while rst is high; fault = 0; fault_pc = 0. inst_data/inst_pc are 0 when the queue is empty after reset.
- Reset mid-operation clears all state. Responses arriving after reset deasserts for pre-reset requests are a system error; the memory must be reset together with the IFU.

## Timing
- First request: imem_req_valid = 1 with addr PC_RST_VEC in the first cycle after rst deasserts.
- Back-to-back: with ready held high and responses returning promptly, one request per cycle, sustaining 1 instruction/cycle.
- Response at cycle M → inst_valid at M+1. The queue is registered with no bypass.
- Redirect at cycle N → imem_req_addr = redirect_pc at N+1; inst_valid = 0 at N+1.
- Stall: with inst_ready = 0, requests stop once inflight + occ = FIFO_DEPTH.

## Configuration
- IFU_MISALIGN_CHK_EN defined: a redirect with redirect_pc[1:0] != 0 does the normal flush/discard, then:
  - sets fault = 1 and fault_pc = redirect_pc at N+1;
  - holds imem_req_valid = 0 while fault is set.
  - A later aligned redirect clears fault and resumes fetch; a later misaligned redirect updates fault_pc.
- Undefined: redirect_pc[1:0] is forced to 2'b00; fault and fault_pc are tied to 0.

## Test plan
- Reset release, imem ready = 1, 1-cycle response, inst_ready = 1 → requests 0x0, 0x4, 0x8…; inst_pc 0x0 at first inst_valid, one instruction per cycle after fill.
- FIFO_DEPTH = 4, inst_ready = 0 → exactly 4 requests issued, then imem_req_valid = 0; queue holds 0x0–0xC; raising inst_ready resumes at 0x10.
- 3 requests in flight, redirect to 0x100 → 3 responses dropped; first inst_pc = 0x100; next req addr 0x100 the cycle after redirect.
- Redirect coincident with request handshake at 0x8 and a response for 0x0 → response dropped, 0x8 counted in discard; no 0x0/0x8 instruction is ever presented.
- imem_req_ready toggling randomly, responses delayed 0–5 cycles → inst_pc strictly sequential, no loss or duplication, fetch_pc wraps 0xFFFFFFFC → 0x0.
- With IFU_MISALIGN_CHK_EN, redirect to 0x102 → fault = 1, fault_pc = 0x102, no requests; redirect to 0x200 → fault = 0, fetch at 0x200. Without the macro, the same redirect fetches 0x100.

Source files
------------

// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: fetch-side bus bundle (imem request/response, decode queue head, redirect, fault)
// master: driven by the IFU; slave: the memory/decode/redirect environment.
interface ifu_prefetch_if #(parameter int XLEN = 32);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] fetch_pc;
  logic            fault;
  logic [XLEN-1:0] fault_pc;
  modport master(
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, fetch_pc, fault, fault_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );
  modport slave(
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, fetch_pc, fault, fault_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: in-order prefetching fetch unit with FIFO_DEPTH-entry {pc, instruction} queue
// Ports: clk, rst (async, active-high), bus (ifu_prefetch_if.master: imem req/rsp, redirect,
// decode head inst_*, fetch_pc, fault/fault_pc). Define IFU_MISALIGN_CHK_EN to fault on
// misaligned redirect targets; otherwise targets are forced word-aligned and fault is 0.
module ifu_prefetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] PC_RST_VEC = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  ifu_prefetch_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = FIFO_DEPTH[CW:0];
  logic [XLEN-1:0] fetch_pc, rsp_pc, tgt, fault_pc;
  logic [CW-1:0] inflight, occ, discard, inflight_nx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [XLEN-1:0] q_pc [FIFO_DEPTH];
  logic [31:0] q_data [FIFO_DEPTH];
  logic fault, req_fire, rsp, push, pop, redir, bad;
`ifdef IFU_MISALIGN_CHK_EN
  assign tgt = bus.redirect_pc;
  assign bad = |bus.redirect_pc[1:0];
`else
  assign tgt = bus.redirect_pc & ~XLEN'(3);
  assign bad = 1'b0;
`endif
  // credit counts both in-flight and buffered fetches so the queue can never overflow
  assign bus.imem_req_valid = ({1'b0, inflight} + {1'b0, occ} < DEPTH) && !fault && !rst;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp = bus.imem_rsp_valid;
  assign redir = bus.redirect_valid;
  assign push = rsp && discard == '0 && !redir;
  assign pop = occ != '0 && bus.inst_ready && !redir;
  assign inflight_nx = inflight + CW'(req_fire) - CW'(rsp);
  assign bus.inst_valid = occ != '0;
  assign bus.inst_pc = bus.inst_valid ? q_pc[rd_ptr] : '0;
  assign bus.inst_data = bus.inst_valid ? q_data[rd_ptr] : '0;
  assign bus.imem_req_addr = fetch_pc;
  assign bus.fetch_pc = fetch_pc;
  assign bus.fault = fault;
  assign bus.fault_pc = fault_pc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= PC_RST_VEC;
      rsp_pc <= PC_RST_VEC;
      inflight <= '0;
      occ <= '0;
      discard <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fault <= 1'b0;
      fault_pc <= '0;
    end else begin
      inflight <= inflight_nx;
      if (redir) begin
        // everything still outstanding after this edge, including a request issued now, is stale
        fetch_pc <= tgt;
        rsp_pc <= tgt;
        occ <= '0;
        discard <= inflight_nx;
        wr_ptr <= '0;
        rd_ptr <= '0;
        fault <= bad;
        if (bad) fault_pc <= tgt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp && discard != '0) discard <= discard - CW'(1);
        if (push) rsp_pc <= rsp_pc + XLEN'(4);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr] <= rsp_pc;
      q_data[wr_ptr] <= bus.imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: table-driven, directed and randomized checks of ifu_prefetch against an epoch-tagged scoreboard
module tb_ifu_prefetch;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST_VEC = 32'h0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ifu_prefetch_if #(.XLEN(XLEN)) bus();
  ifu_prefetch #(.XLEN(XLEN), .PC_RST_VEC(RST_VEC), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {logic [31:0] addr; int ep; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} ins_t;
  typedef struct {bit rdy; bit ir; bit rd; logic [31:0] rpc; bit e_rv; logic [31:0] e_addr; bit e_iv; logic [31:0] e_pc;} vec_t;
  req_t mq[$];
  ins_t bq[$];
  int epoch, cyc, dly, passed, total;
  logic [31:0] mfetch, mfault_pc, last_pop;
  logic mfault;
  bit wrapped, found;
  vec_t tbl[15];
  function automatic logic [31:0] dat(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h, expected %h", n, a, e);
  endtask
  task automatic step();
    logic fire, pop, rv;
    ins_t h;
    req_t r;
    rv = mq.size() != 0 && mq[0].due <= cyc + 1;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data = rv ? dat(mq[0].addr) : 32'h0;
    chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, (mq.size() + bq.size() < DEPTH) && !mfault});
    chk("fetch_pc", bus.fetch_pc, mfetch);
    chk("req_addr", bus.imem_req_addr, mfetch);
    chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, bq.size() != 0});
    if (bq.size() != 0) begin
      chk("inst_pc", bus.inst_pc, bq[0].pc);
      chk("inst_data", bus.inst_data, bq[0].data);
    end
    chk("fault", {31'b0, bus.fault}, {31'b0, mfault});
    chk("fault_pc", bus.fault_pc, mfault_pc);
    fire = bus.imem_req_valid && bus.imem_req_ready;
    pop = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
    @(posedge clk);
    cyc++;
    if (pop && bq.size() != 0) begin
      h = bq.pop_front();
      if (h.pc == 32'h0 && last_pop == 32'hFFFFFFFC) wrapped = 1;
      last_pop = h.pc;
    end
    if (rv) begin
      r = mq.pop_front();
      if (!bus.redirect_valid && r.ep == epoch) bq.push_back('{r.addr, dat(r.addr)});
    end
    if (fire) begin
      mq.push_back('{mfetch, epoch, cyc + 1 + dly});
      mfetch += 32'd4;
    end
    if (bus.redirect_valid) begin
      epoch++;
      bq.delete();
`ifdef IFU_MISALIGN_CHK_EN
      mfault = bus.redirect_pc[1:0] != 2'b00;
      if (mfault) mfault_pc = bus.redirect_pc;
      mfetch = bus.redirect_pc;
`else
      mfetch = bus.redirect_pc & ~32'd3;
`endif
    end
    #1;
    bus.redirect_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.inst_ready = 1'b0;
    mq.delete();
    bq.delete();
    epoch = 0;
    dly = 0;
    mfetch = RST_VEC;
    mfault = 1'b0;
    mfault_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    chk("rst_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    chk("rst_fetch_pc", bus.fetch_pc, RST_VEC);
    chk("rst_fault", {31'b0, bus.fault}, 32'h0);
    chk("rst_fault_pc", bus.fault_pc, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_inst_data", bus.inst_data, 32'h0);
    rst = 1'b0;
    #1;
    chk("first_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    chk("first_req_addr", bus.imem_req_addr, RST_VEC);
  endtask
  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = pc;
  endtask
  initial begin
    logic [31:0] rpc;
    passed = 0;
    total = 0;
    cyc = 0;
    last_pop = 32'h1;
    wrapped = 0;
    tbl[0]  = '{1, 0, 0, 32'h0,   1, 32'h004, 0, 32'h0};
    tbl[1]  = '{1, 0, 0, 32'h0,   1, 32'h008, 1, 32'h0};
    tbl[2]  = '{1, 0, 0, 32'h0,   1, 32'h00C, 1, 32'h0};
    tbl[3]  = '{1, 0, 0, 32'h0,   0, 32'h010, 1, 32'h0};
    tbl[4]  = '{1, 0, 0, 32'h0,   0, 32'h010, 1, 32'h0};
    tbl[5]  = '{1, 0, 0, 32'h0,   0, 32'h010, 1, 32'h0};
    tbl[6]  = '{1, 1, 0, 32'h0,   1, 32'h010, 1, 32'h4};
    tbl[7]  = '{1, 1, 0, 32'h0,   1, 32'h014, 1, 32'h8};
    tbl[8]  = '{1, 1, 0, 32'h0,   1, 32'h018, 1, 32'hC};
    tbl[9]  = '{1, 1, 0, 32'h0,   1, 32'h01C, 1, 32'h10};
    tbl[10] = '{1, 1, 1, 32'h100, 1, 32'h100, 0, 32'h0};
    tbl[11] = '{1, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0};
    tbl[12] = '{1, 1, 0, 32'h0,   1, 32'h108, 1, 32'h100};
    tbl[13] = '{1, 1, 0, 32'h0,   1, 32'h10C, 1, 32'h104};
    tbl[14] = '{0, 1, 0, 32'h0,   1, 32'h10C, 1, 32'h108};
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.imem_req_ready = tbl[i].rdy;
      bus.inst_ready = tbl[i].ir;
      bus.redirect_valid = tbl[i].rd;
      bus.redirect_pc = tbl[i].rpc;
      step();
      chk($sformatf("tbl%0d_req_valid", i), {31'b0, bus.imem_req_valid}, {31'b0, tbl[i].e_rv});
      chk($sformatf("tbl%0d_req_addr", i), bus.imem_req_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_inst_valid", i), {31'b0, bus.inst_valid}, {31'b0, tbl[i].e_iv});
      if (tbl[i].e_iv) chk($sformatf("tbl%0d_inst_pc", i), bus.inst_pc, tbl[i].e_pc);
    end
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    dly = 5;
    repeat (3) step();
    bus.imem_req_ready = 1'b0;
    redirect(32'h100);
    step();
    chk("redir_req_addr", bus.imem_req_addr, 32'h100);
    chk("redir_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    bus.imem_req_ready = 1'b1;
    dly = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = bus.inst_valid;
    end
    chk("redir_first_valid", {31'b0, found}, 32'h1);
    chk("redir_first_pc", bus.inst_pc, 32'h100);
    redirect(32'hFFFFFFF8);
    repeat (10) step();
    chk("wrap_seen", {31'b0, wrapped}, 32'h1);
    redirect(32'h102);
    step();
`ifdef IFU_MISALIGN_CHK_EN
    chk("mis_fault", {31'b0, bus.fault}, 32'h1);
    chk("mis_fault_pc", bus.fault_pc, 32'h102);
    repeat (4) step();
    chk("mis_no_req", {31'b0, bus.imem_req_valid}, 32'h0);
    redirect(32'h200);
    step();
    chk("mis_clear", {31'b0, bus.fault}, 32'h0);
    chk("mis_resume_addr", bus.imem_req_addr, 32'h200);
    chk("mis_resume_valid", {31'b0, bus.imem_req_valid}, 32'h1);
`else
    chk("mis_fault", {31'b0, bus.fault}, 32'h0);
    chk("mis_aligned_addr", bus.imem_req_addr, 32'h100);
`endif
    repeat (6) step();
    for (int i = 0; i < 3000; i++) begin
      bus.imem_req_ready = $urandom_range(0, 3) != 0;
      bus.inst_ready = $urandom_range(0, 3) != 0;
      dly = $urandom_range(0, 5);
      if ($urandom_range(0, 49) == 0) begin
        rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 : ($urandom & 32'hFFFFFFFC);
        if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
        redirect(rpc);
      end
      step();
    end
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    repeat (20) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
